// File: rtl/multi_share_ctrl.sv
// -----------------------------------------------------------------------------
// multi_share_ctrl
//
// Time-shares one 32-bit multi-cycle compute unit between two requesters.
// The unit is driven one operation at a time (start/inp -> done/out). Each
// result, or an error if the unit hangs, is routed back to the requester that
// issued the operation. Grants are round-robin and alternate on each
// completed response handshake.
//
// Parameters
//   TIMEOUT      Maximum number of BUSY cycles spent waiting for unit_done
//                before the operation is aborted (legal range 2..255).
//
// Ports
//   clock        Sole clock. All state updates on its rising edge.
//   reset        Synchronous, active-high reset.
//   req0_*       Request channel 0: valid/ready handshake plus 32-bit operand.
//   req1_*       Request channel 1: same as channel 0.
//   resp0_*      Response channel 0: valid/ready handshake, 32-bit result,
//                and an error flag. The result is 0 when the error flag is set.
//   resp1_*      Response channel 1: same as channel 0.
//   unit_start   One-cycle start pulse to the compute unit.
//   unit_inp     Operand to the compute unit. Valid while unit_start is high.
//   unit_reset   Reset to the compute unit: reset OR a one-cycle abort pulse.
//   unit_done    Compute unit result-valid strobe.
//   unit_out     Compute unit result.
// -----------------------------------------------------------------------------
module multi_share_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_data,

  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic [31:0] resp0_data,
  output logic        resp0_err,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [31:0] resp1_data,
  output logic        resp1_err,

  output logic        unit_start,
  output logic [31:0] unit_inp,
  output logic        unit_reset,
  input  logic        unit_done,
  input  logic [31:0] unit_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // The watchdog count holds the number of completed BUSY cycles. The current
  // BUSY cycle is therefore number wd_cnt+1, and the abort fires when that
  // number equals TIMEOUT.
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic        prio;     // requester that wins when both are valid
  logic        owner;    // requester that issued the operation in flight
  logic [31:0] result;
  logic        err;
  logic [7:0]  wd_cnt;

  logic        idle_live;
  logic        resp_live;
  logic        grant_any;
  logic        grant_sel;
  logic        timeout_hit;
  logic        resp_taken;

  // ---------------------------------------------------------------------------
  // Grant, abort and response decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default at the top,
  // so that no path through the block leaves it unassigned and infers a latch.
  always_comb begin
    idle_live   = 1'b0;
    resp_live   = 1'b0;
    grant_any   = 1'b0;
    grant_sel   = 1'b0;
    timeout_hit = 1'b0;
    resp_taken  = 1'b0;

    // Reset overrides everything, so nothing is offered while it is held.
    idle_live = (state == IDLE) && !reset;
    resp_live = (state == RESP) && !reset;

    grant_any = req0_valid || req1_valid;
    // Under contention the priority holder wins; otherwise whoever is valid.
    grant_sel = (req0_valid && req1_valid) ? prio : req1_valid;

    // A done arriving in the last allowed cycle beats the abort.
    timeout_hit = (state == BUSY) && !reset && !unit_done && (wd_cnt == WD_LAST);

    // Only the owner's ready counts; the other port is ignored.
    resp_taken = owner ? resp1_ready : resp0_ready;
  end

  assign req0_ready  = idle_live && grant_any && !grant_sel;
  assign req1_ready  = idle_live && grant_any &&  grant_sel;

  assign unit_start  = idle_live && grant_any;
  assign unit_inp    = unit_start ? (grant_sel ? req1_data : req0_data) : 32'd0;
  assign unit_reset  = reset || timeout_hit;

  assign resp0_valid = resp_live && !owner;
  assign resp1_valid = resp_live &&  owner;
  assign resp0_data  = resp0_valid ? result : 32'd0;
  assign resp1_data  = resp1_valid ? result : 32'd0;
  assign resp0_err   = resp0_valid && err;
  assign resp1_err   = resp1_valid && err;

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  // NOTE: state is updated only with non-blocking assignments, so every
  // register samples values from before the edge and ordering between
  // statements cannot change the result.
  always_ff @(posedge clock) begin
    // NOTE: reset is sampled on the clock edge here, not asynchronously,
    // and it clears every register including result, so a stale operand can
    // never reach a response port after reset.
    if (reset) begin
      state  <= IDLE;
      prio   <= 1'b0;
      owner  <= 1'b0;
      result <= 32'd0;
      err    <= 1'b0;
      wd_cnt <= 8'd0;
    end else begin
      unique case (state)
        IDLE: begin
          // unit_done is ignored here, so a late strobe cannot disturb result.
          if (grant_any) begin
            owner  <= grant_sel;
            wd_cnt <= 8'd0;
            state  <= BUSY;
          end
        end

        BUSY: begin
          wd_cnt <= wd_cnt + 8'd1;
          if (unit_done) begin
            result <= unit_out;
            err    <= 1'b0;
            state  <= RESP;
          end else if (timeout_hit) begin
            result <= 32'd0;
            err    <= 1'b1;
            state  <= RESP;
          end
        end

        RESP: begin
          // No watchdog applies here: a stalled requester holds RESP forever.
          // Priority moves on every handshake, including errored operations.
          if (resp_taken) begin
            prio  <= !owner;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_share_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multi_share_ctrl
//
// Directed bench for multi_share_ctrl with TIMEOUT = 4. A small behavioural
// compute unit returns (operand << 1) a programmable number of cycles after
// start, or never when disabled. A force path injects spurious done strobes.
// Inputs change 2 time units after each rising edge. Outputs are checked one
// unit later.
// -----------------------------------------------------------------------------
module tb_multi_share_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_data, req1_data;
  logic        resp0_valid, resp0_ready, resp0_err;
  logic        resp1_valid, resp1_ready, resp1_err;
  logic [31:0] resp0_data, resp1_data;
  logic        unit_start, unit_reset, unit_done;
  logic [31:0] unit_inp, unit_out;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  multi_share_ctrl #(.TIMEOUT(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_data   (req0_data),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_data   (req1_data),
    .resp0_valid (resp0_valid),
    .resp0_ready (resp0_ready),
    .resp0_data  (resp0_data),
    .resp0_err   (resp0_err),
    .resp1_valid (resp1_valid),
    .resp1_ready (resp1_ready),
    .resp1_data  (resp1_data),
    .resp1_err   (resp1_err),
    .unit_start  (unit_start),
    .unit_inp    (unit_inp),
    .unit_reset  (unit_reset),
    .unit_done   (unit_done),
    .unit_out    (unit_out)
  );

  // Behavioural compute unit: done in cycle unit_lat after the start cycle.
  int          unit_lat   = 3;
  logic        unit_en    = 1'b1;
  logic        force_done = 1'b0;
  logic [31:0] force_val  = 32'hDEAD_BEEF;
  logic        model_pend = 1'b0;
  int          model_cnt  = 0;
  logic [31:0] model_val  = 32'd0;
  logic        model_done;

  assign model_done = model_pend && unit_en && (model_cnt == unit_lat);
  assign unit_done  = model_done || force_done;
  assign unit_out   = force_done ? force_val : model_val;

  always @(posedge clock) begin
    if (unit_reset) begin
      model_pend <= 1'b0;
      model_cnt  <= 0;
    end else if (unit_start) begin
      model_pend <= 1'b1;
      model_cnt  <= 1;
      model_val  <= unit_inp << 1;
    end else if (model_done) begin
      model_pend <= 1'b0;
    end else if (model_pend) begin
      model_cnt  <= model_cnt + 1;
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "time limit reached");
  end

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data  = 32'd0; req1_data = 32'd0;
    resp0_ready = 1'b0; resp1_ready = 1'b0;

    // ---- Reset state: nothing offered even with a request pending ----
    next_cycle();
    next_cycle();
    req0_valid = 1'b1;
    #1;
    check("rst_unit_reset",  unit_reset,  1);
    check("rst_req0_ready",  req0_ready,  0);
    check("rst_unit_start",  unit_start,  0);
    check("rst_resp0_valid", resp0_valid, 0);
    check("rst_resp1_valid", resp1_valid, 0);
    check("rst_resp0_data",  resp0_data,  0);
    check("rst_resp0_err",   resp0_err,   0);
    next_cycle();
    reset = 1'b0;
    req0_valid = 1'b0;
    #1;
    check("post_rst_unit_reset", unit_reset, 0);
    check("post_rst_unit_start", unit_start, 0);

    // ---- Single op: req0 = 5, L = 3, expect 0xA four cycles after accept ----
    next_cycle();
    req0_valid = 1'b1; req0_data = 32'h5;
    #1;
    check("single_req0_ready", req0_ready, 1);
    check("single_req1_ready", req1_ready, 0);
    check("single_unit_start", unit_start, 1);
    check("single_unit_inp",   unit_inp,   32'h5);
    for (int b = 1; b <= 3; b++) begin
      next_cycle();
      req0_valid = 1'b0;
      #1;
      check("single_busy_start", unit_start,  0);
      check("single_busy_resp0", resp0_valid, 0);
      check("single_busy_resp1", resp1_valid, 0);
    end
    next_cycle();
    #1;
    check("single_resp0_valid", resp0_valid, 1);
    check("single_resp0_data",  resp0_data,  32'hA);
    check("single_resp0_err",   resp0_err,   0);
    check("single_resp1_valid", resp1_valid, 0);
    resp0_ready = 1'b1;
    next_cycle();
    resp0_ready = 1'b0;
    #1;
    check("single_after_resp0", resp0_valid, 0);

    // ---- Contention: both valid, ready high -> grants 0,1,0,1 ----
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    next_cycle();
    req0_valid = 1'b1; req0_data = 32'h11;
    req1_valid = 1'b1; req1_data = 32'h22;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("cont_req0_ready", req0_ready, (k % 2) == 0);
      check("cont_req1_ready", req1_ready, (k % 2) == 1);
      check("cont_unit_inp",   unit_inp,   ((k % 2) == 1) ? 32'h22 : 32'h11);
      for (int b = 1; b <= 3; b++) begin
        next_cycle();
        #1;
        check("cont_busy_req0_ready", req0_ready, 0);
        check("cont_busy_req1_ready", req1_ready, 0);
      end
      next_cycle();
      #1;
      check("cont_resp0_valid", resp0_valid, (k % 2) == 0);
      check("cont_resp1_valid", resp1_valid, (k % 2) == 1);
      if ((k % 2) == 1) check("cont_resp1_data", resp1_data, 32'h44);
      else              check("cont_resp0_data", resp0_data, 32'h22);
      next_cycle();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    resp0_ready = 1'b0; resp1_ready = 1'b0;

    // ---- Backpressure on resp1, late done in RESP, then grant to 0 ----
    req1_valid = 1'b1; req1_data = 32'h30;
    #1;
    check("bp_req1_ready", req1_ready, 1);
    check("bp_unit_inp",   unit_inp,   32'h30);
    next_cycle();
    req0_valid = 1'b1; req0_data = 32'h40;
    #1;
    check("bp_busy_req0_ready", req0_ready, 0);
    check("bp_busy_req1_ready", req1_ready, 0);
    next_cycle();
    next_cycle();
    next_cycle();
    for (int s = 0; s < 5; s++) begin
      force_done = (s == 2);
      #1;
      check("bp_stall_resp1_valid", resp1_valid, 1);
      check("bp_stall_resp1_data",  resp1_data,  32'h60);
      check("bp_stall_resp1_err",   resp1_err,   0);
      check("bp_stall_unit_start",  unit_start,  0);
      check("bp_stall_req0_ready",  req0_ready,  0);
      next_cycle();
    end
    force_done = 1'b0;
    resp1_ready = 1'b1;
    #1;
    check("bp_hs_resp1_data", resp1_data, 32'h60);
    next_cycle();
    resp1_ready = 1'b0;
    #1;
    check("bp_next_req0_ready", req0_ready, 1);
    check("bp_next_req1_ready", req1_ready, 0);
    check("bp_next_unit_inp",   unit_inp,   32'h40);
    req1_valid = 1'b0;
    resp0_ready = 1'b1;
    next_cycle();
    req0_valid = 1'b0;
    next_cycle();
    next_cycle();
    next_cycle();
    #1;
    check("bp_resp0_valid", resp0_valid, 1);
    check("bp_resp0_data",  resp0_data,  32'h80);
    next_cycle();

    // ---- Timeout: unit never answers, abort in BUSY cycle 4 ----
    unit_en = 1'b0;
    req0_valid = 1'b1; req0_data = 32'h7;
    #1;
    check("to_req0_ready", req0_ready, 1);
    for (int b = 1; b <= 4; b++) begin
      next_cycle();
      req0_valid = 1'b0;
      #1;
      check("to_unit_reset", unit_reset, b == 4);
      check("to_resp0_valid", resp0_valid, 0);
    end
    next_cycle();
    #1;
    check("to_resp0_valid_err", resp0_valid, 1);
    check("to_resp0_err",       resp0_err,   1);
    check("to_resp0_data",      resp0_data,  32'h0);
    check("to_resp_unit_reset", unit_reset,  0);
    next_cycle();
    unit_en = 1'b1;
    req1_valid = 1'b1; req1_data = 32'h21;
    resp1_ready = 1'b1;
    #1;
    check("to_next_req1_ready", req1_ready, 1);
    next_cycle();
    req1_valid = 1'b0;
    next_cycle();
    next_cycle();
    next_cycle();
    #1;
    check("to_next_resp1_valid", resp1_valid, 1);
    check("to_next_resp1_data",  resp1_data,  32'h42);
    check("to_next_resp1_err",   resp1_err,   0);
    next_cycle();

    // ---- Done in BUSY cycle TIMEOUT: done wins, no abort ----
    unit_lat = 4;
    req0_valid = 1'b1; req0_data = 32'h9;
    #1;
    check("edge_req0_ready", req0_ready, 1);
    for (int b = 1; b <= 4; b++) begin
      next_cycle();
      req0_valid = 1'b0;
      #1;
      check("edge_unit_reset", unit_reset, 0);
    end
    next_cycle();
    #1;
    check("edge_resp0_valid", resp0_valid, 1);
    check("edge_resp0_err",   resp0_err,   0);
    check("edge_resp0_data",  resp0_data,  32'h12);
    next_cycle();
    unit_lat = 3;

    // ---- Reset during BUSY: no response, prio back to 0, late done ignored ----
    req1_valid = 1'b1; req1_data = 32'h50;
    #1;
    check("rb_req1_ready", req1_ready, 1);
    next_cycle();
    req1_valid = 1'b0;
    next_cycle();
    reset = 1'b1;
    #1;
    check("rb_unit_reset",  unit_reset,  1);
    check("rb_resp1_valid", resp1_valid, 0);
    next_cycle();
    reset = 1'b0;
    force_done = 1'b1;
    #1;
    check("rb_idle_unit_reset", unit_reset,  0);
    check("rb_idle_resp1",      resp1_valid, 0);
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      force_done = 1'b0;
      #1;
      check("rb_quiet_resp0", resp0_valid, 0);
      check("rb_quiet_resp1", resp1_valid, 0);
    end
    req0_valid = 1'b1; req0_data = 32'h3;
    req1_valid = 1'b1; req1_data = 32'h4;
    #1;
    check("rb_prio_req0_ready", req0_ready, 1);
    check("rb_prio_req1_ready", req1_ready, 0);
    check("rb_prio_unit_inp",   unit_inp,   32'h3);
    next_cycle();
    req0_valid = 1'b0; req1_valid = 1'b0;
    next_cycle();
    next_cycle();
    next_cycle();
    #1;
    check("rb_resp0_valid", resp0_valid, 1);
    check("rb_resp0_data",  resp0_data,  32'h6);
    check("rb_resp1_valid", resp1_valid, 0);
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
